gate2_sweep_checker: RTL and testbench

- Self-contained stimulus-and-check stage for 2-input combinational gate blocks such as the De Morgan NAND-equivalent.
- Feeds the gate's a/b inputs with an exhaustive 2-bit pattern sweep and consumes its c output.
- Compares each sampled c against a parameterised expected truth table and reports pass/fail plus per-pattern mismatch flags.
- Sits on the board between push-button/switch logic (start) and LEDs (pass/done/err_mask); replaces free-running testbench toggling with a synthesizable, clocked sweep.

---
 rtl/gate2_pkg.sv | 19 +
 rtl/gate2_pattern_gen.sv | 19 +
 rtl/gate2_sweep_checker.sv | 107 ++++++++++
 tb/tb_gate2_sweep_checker.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gate2_pkg.sv
// Shared types and constants for the 2-input gate sweep checker.
package gate2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  // Truth tables indexed by {a,b}: bit0 = a0b0 ... bit3 = a1b1.
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] NOR_TT  = 4'b0001;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;

  localparam int unsigned PATTERN_COUNT = 4;

endpackage

// File: rtl/gate2_pattern_gen.sv
// Maps sweep index to the {a,b} pattern driven into the gate under check.
// Build option: GATE2_GRAY_ORDER_EN selects Gray order 00,01,11,10 instead of binary.
module gate2_pattern_gen
  import gate2_pkg::*;
(
  input  logic [$clog2(PATTERN_COUNT)-1:0] idx,
  output logic                             a,
  output logic                             b
);

  always_comb begin
`ifdef GATE2_GRAY_ORDER_EN
    {a, b} = idx ^ {1'b0, idx[1]};
`else
    {a, b} = idx;
`endif
  end

endmodule

// File: rtl/gate2_sweep_checker.sv
// Clocked exhaustive sweep of a 2-input gate with truth-table scoreboard.
// Build option: GATE2_GRAY_ORDER_EN (Gray pattern order, see gate2_pattern_gen).
module gate2_sweep_checker
  import gate2_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [3:0]  EXPECTED    = NAND_TT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] obs_table,
  output logic [3:0] err_mask,
  output logic [2:0] err_count
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [1:0] gen_idx;
  logic [7:0] hold;
  logic       gen_a;
  logic       gen_b;
  logic [1:0] p;

  // Pattern for the DRIVE phase about to be entered, so dut_a/dut_b are registered on entry.
  always_comb begin
    gen_idx = (state == IDLE) ? '0 : idx + 2'd1;
    p       = {dut_a, dut_b};
  end

  gate2_pattern_gen u_pattern_gen (
    .idx (gen_idx),
    .a   (gen_a),
    .b   (gen_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      hold      <= '0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      obs_table <= '0;
      err_mask  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state          <= DRIVE;
            busy           <= 1'b1;
            pass           <= 1'b0;
            obs_table      <= '0;
            err_mask       <= '0;
            err_count      <= '0;
            idx            <= '0;
            hold           <= '0;
            {dut_a, dut_b} <= {gen_a, gen_b};
          end
        end
        DRIVE: begin
          hold <= hold + 8'd1;
          if (hold == HOLD_LAST) state <= SAMPLE;
        end
        SAMPLE: begin
          obs_table[p] <= dut_c;
          if (dut_c != EXPECTED[p]) begin
            err_mask[p] <= 1'b1;
            err_count   <= err_count + 3'd1;
          end
          if (idx == 2'd3) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            state          <= DRIVE;
            idx            <= idx + 2'd1;
            hold           <= '0;
            {dut_a, dut_b} <= {gen_a, gen_b};
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_count == 3'd0);
          dut_a <= 1'b0;
          dut_b <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate2_sweep_checker.sv
// Directed, table-driven bench for gate2_sweep_checker (HOLD_CYCLES=2 and HOLD_CYCLES=1 instances).
module tb_gate2_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;
  logic [3:0] gate_tt = 4'b0111;

  logic dut_a, dut_b, dut_c, busy, done, pass;
  logic [3:0] obs_table, err_mask;
  logic [2:0] err_count;
  logic a1, b1, c1, busy1, done1, pass1;
  logic [3:0] obs1, mask1;
  logic [2:0] cnt1;

  always #5 clk = ~clk;

  // Gate model: truth table indexed by {a,b}.
  always_comb begin
    dut_c = gate_tt[{dut_a, dut_b}];
    c1    = gate_tt[{a1, b1}];
  end

  gate2_sweep_checker #(.HOLD_CYCLES(2), .EXPECTED(4'b0111)) dut (
    .clk(clk), .rst(rst), .start(start), .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c),
    .busy(busy), .done(done), .pass(pass), .obs_table(obs_table), .err_mask(err_mask),
    .err_count(err_count)
  );

  gate2_sweep_checker #(.HOLD_CYCLES(1), .EXPECTED(4'b0111)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_b(b1), .dut_c(c1),
    .busy(busy1), .done(done1), .pass(pass1), .obs_table(obs1), .err_mask(mask1),
    .err_count(cnt1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] tt;
    logic [3:0] obs;
    logic [3:0] mask;
    logic [2:0] cnt;
    logic       pass;
    bit         repulse;
  } vec_t;

  vec_t       vecs[7];
  logic [1:0] order[4];
  logic [1:0] ab_log[0:31];
  logic       busy_log[0:31];
  logic       pass_k1;
  int         done_k;
  int         n_done;

  // Pulses start, then logs outputs at each following negedge k=1..24.
  task automatic sweep0(input bit repulse);
    done_k = -1;
    n_done = 0;
    @(negedge clk) start = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      start = repulse && (k == 3 || k == 7 || k == 13);
      ab_log[k]   = {dut_a, dut_b};
      busy_log[k] = busy;
      if (k == 1) pass_k1 = pass;
      if (done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
    end
    start = 1'b0;
  endtask

  initial begin
`ifdef GATE2_GRAY_ORDER_EN
    order[0] = 2'b00; order[1] = 2'b01; order[2] = 2'b11; order[3] = 2'b10;
`else
    order[0] = 2'b00; order[1] = 2'b01; order[2] = 2'b10; order[3] = 2'b11;
`endif
    //           gate     obs      mask     cnt   pass  repulse
    vecs[0] = '{4'b0111, 4'b0111, 4'b0000, 3'd0, 1'b1, 1'b0};  // NAND
    vecs[1] = '{4'b1000, 4'b1000, 4'b1111, 3'd4, 1'b0, 1'b0};  // AND
    vecs[2] = '{4'b1111, 4'b1111, 4'b1000, 3'd1, 1'b0, 1'b0};  // stuck at 1
    vecs[3] = '{4'b0001, 4'b0001, 4'b0110, 3'd2, 1'b0, 1'b0};  // NOR
    vecs[4] = '{4'b1110, 4'b1110, 4'b1001, 3'd2, 1'b0, 1'b0};  // OR
    vecs[5] = '{4'b0000, 4'b0000, 4'b0111, 3'd3, 1'b0, 1'b0};  // stuck at 0
    vecs[6] = '{4'b0111, 4'b0111, 4'b0000, 3'd0, 1'b1, 1'b1};  // NAND, start re-pulsed

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dut_a", dut_a, 0);
    check("rst_dut_b", dut_b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_obs", obs_table, 0);
    check("rst_mask", err_mask, 0);
    check("rst_count", err_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      bit seq_ok;
      gate_tt = vecs[i].tt;
      sweep0(vecs[i].repulse);
      seq_ok = 1'b1;
      for (int k = 1; k <= 12; k++)
        if (ab_log[k] !== order[(k - 1) / 3]) seq_ok = 1'b0;
      check($sformatf("v%0d_ab_seq", i), seq_ok, 1);
      check($sformatf("v%0d_ab_idle", i), ab_log[14], 0);
      check($sformatf("v%0d_done_k", i), done_k, 14);
      check($sformatf("v%0d_n_done", i), n_done, 1);
      check($sformatf("v%0d_pass_clr", i), pass_k1, 0);
      check($sformatf("v%0d_busy12", i), busy_log[12], 1);
      check($sformatf("v%0d_busy13", i), busy_log[13], 0);
      check($sformatf("v%0d_busy_end", i), busy_log[24], 0);
      check($sformatf("v%0d_obs", i), obs_table, vecs[i].obs);
      check($sformatf("v%0d_mask", i), err_mask, vecs[i].mask);
      check($sformatf("v%0d_count", i), err_count, vecs[i].cnt);
      check($sformatf("v%0d_pass", i), pass, vecs[i].pass);
    end

    // Reset mid-sweep: abort immediately, no done afterwards.
    gate_tt = 4'b0111;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_obs_pre", obs_table, 4'b0001);
    rst = 1'b1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_ab", {dut_a, dut_b}, 0);
    check("mid_obs", obs_table, 0);
    check("mid_count", err_count, 0);
    @(negedge clk) rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("mid_no_done", n_done, 0);

    // start in the same cycle rst deasserts is accepted.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) begin rst = 1'b0; start = 1'b1; end
    done_k = -1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) check("rel_busy", busy, 1);
      if (done && done_k < 0) done_k = k;
    end
    check("rel_done_k", done_k, 14);
    check("rel_pass", pass, 1);

    // HOLD_CYCLES=1 instance.
    done_k = -1;
    @(negedge clk) start1 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      ab_log[k] = {a1, b1};
      if (done1 && done_k < 0) done_k = k;
    end
    begin
      bit seq_ok;
      seq_ok = 1'b1;
      for (int k = 1; k <= 8; k++)
        if (ab_log[k] !== order[(k - 1) / 2]) seq_ok = 1'b0;
      check("h1_ab_seq", seq_ok, 1);
    end
    check("h1_done_k", done_k, 10);
    check("h1_obs", obs1, 4'b0111);
    check("h1_mask", mask1, 0);
    check("h1_count", cnt1, 0);
    check("h1_pass", pass1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
